// File: rtl/icache_pkg.sv
// Shared types, constants and width helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT
    } icache_state_e;

    function automatic int unsigned offset_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned index_width(input int unsigned line_count);
        return $clog2(line_count);
    endfunction

    function automatic int unsigned tag_width(input int unsigned line_count,
                                              input int unsigned words_per_line);
        return 30 - offset_width(words_per_line) - index_width(line_count);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid, tag and data arrays: one combinational read port, one word write port,
// a line commit that sets valid and tag, and a clear-all of the valid bits.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned LineCount    = 16,
    parameter int unsigned WordsPerLine = 4,
    localparam int unsigned OffW = offset_width(WordsPerLine),
    localparam int unsigned IdxW = index_width(LineCount),
    localparam int unsigned TagW = tag_width(LineCount, WordsPerLine)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IdxW-1:0] rd_index,
    input  logic [OffW-1:0] rd_offset,
    output logic            rd_valid,
    output logic [TagW-1:0] rd_tag,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [IdxW-1:0] wr_index,
    input  logic [OffW-1:0] wr_offset,
    input  logic [31:0]     wr_data,
    input  logic            commit,
    input  logic [TagW-1:0] commit_tag,
    input  logic            clear_all
);

    logic [LineCount-1:0] valid_q;
    logic [TagW-1:0]      tag_q  [LineCount];
    logic [31:0]          data_q [LineCount*WordsPerLine];

    // Clear wins over commit so a refill racing an invalidate leaves the line invalid.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            valid_q <= '0;
        end else if (commit) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            tag_q[wr_index] <= commit_tag;
        end
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, in-order
// single-outstanding line refill, and deferred invalidate during a refill.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int unsigned LineCount    = 16,
    parameter int unsigned WordsPerLine = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] read_address_i,
    output logic [31:0] read_data_o,
    output logic        read_valid_o,
    input  logic        invalidate_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_address_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i
);

    localparam int unsigned OffW = offset_width(WordsPerLine);
    localparam int unsigned IdxW = index_width(LineCount);
    localparam int unsigned TagW = tag_width(LineCount, WordsPerLine);

    icache_state_e   state_q, state_d;
    logic [OffW-1:0] count_q, count_d;
    logic [31:0]     base_q, base_d;
    logic            pending_q, pending_d;

    logic            rd_valid;
    logic [TagW-1:0] rd_tag;
    logic [31:0]     rd_data;
    logic            wr_en, commit, clear_all, hit, last_word;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^read_address_i[1:0];

    icache_line_store #(
        .LineCount    (LineCount),
        .WordsPerLine (WordsPerLine)
    ) u_store (
        .clk        (clk_i),
        .rst        (rst_i),
        .rd_index   (read_address_i[2+OffW +: IdxW]),
        .rd_offset  (read_address_i[2 +: OffW]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_index   (base_q[2+OffW +: IdxW]),
        .wr_offset  (count_q),
        .wr_data    (mem_resp_data_i),
        .commit     (commit),
        .commit_tag (base_q[31 -: TagW]),
        .clear_all  (clear_all)
    );

    assign hit          = (state_q == IDLE) && rd_valid && (rd_tag == read_address_i[31 -: TagW]);
    assign read_valid_o = hit;
    assign read_data_o  = hit ? rd_data : INSTRUCTION_NOP;
    assign last_word    = (count_q == OffW'(WordsPerLine - 1));

    always_comb begin
        state_d           = state_q;
        count_d           = count_q;
        base_d            = base_q;
        pending_d         = pending_q;
        wr_en             = 1'b0;
        commit            = 1'b0;
        clear_all         = 1'b0;
        mem_req_valid_o   = 1'b0;
        mem_req_address_o = '0;
        unique case (state_q)
            IDLE: begin
                clear_all = invalidate_i;
                if (!hit) begin
                    base_d  = {read_address_i[31:OffW+2], {(OffW + 2){1'b0}}};
                    count_d = '0;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                mem_req_valid_o   = 1'b1;
                mem_req_address_o = base_q + 32'({count_q, 2'b00});
                pending_d         = pending_q | invalidate_i;
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                pending_d = pending_q | invalidate_i;
                if (mem_resp_valid_i) begin
                    wr_en = 1'b1;
                    if (last_word) begin
                        // An invalidate seen at any point during the refill discards the new line.
                        if (pending_q || invalidate_i) begin
                            clear_all = 1'b1;
                        end else begin
                            commit = 1'b1;
                        end
                        pending_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        count_d = count_q + 1'b1;
                        state_d = REQUEST;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            base_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            base_q    <= base_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: fills, hits, stalls, conflicts,
// invalidate during refill and reset during refill.
module tb_instruction_cache;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;
    logic        read_valid;
    logic        invalidate = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_address;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    instruction_cache #(
        .LineCount    (16),
        .WordsPerLine (WORDS)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .read_address_i    (read_address),
        .read_data_o       (read_data),
        .read_valid_o      (read_valid),
        .invalidate_i      (invalidate),
        .mem_req_valid_o   (mem_req_valid),
        .mem_req_ready_i   (mem_req_ready),
        .mem_req_address_o (mem_req_address),
        .mem_resp_valid_i  (mem_resp_valid),
        .mem_resp_data_i   (mem_resp_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic start_miss(input logic [31:0] addr);
        @(negedge clk);
        read_address = addr;
        #1;
        check("miss_valid", 32'(read_valid), 32'd0);
        check("miss_data", read_data, NOP);
    endtask

    // Serves one line refill; the first request is stalled 'stall' cycles with stray responses.
    task automatic refill(input logic [31:0] base, input int stall, input bit inval);
        for (int w = 0; w < WORDS; w++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            invalidate     = 1'b0;
            check("req_valid", 32'(mem_req_valid), 32'd1);
            check("req_addr", mem_req_address, base + 32'(4 * w));
            check("refill_nop", 32'(read_valid), 32'd0);
            if (w == 0) begin
                for (int k = 0; k < stall; k++) begin
                    mem_req_ready  = 1'b0;
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = 32'hDEAD_BEEF;
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                    check("stall_valid", 32'(mem_req_valid), 32'd1);
                    check("stall_addr", mem_req_address, base);
                end
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("wait_no_req", 32'(mem_req_valid), 32'd0);
            mem_resp_valid = 1'b1;
            mem_resp_data  = word_of(base + 32'(4 * w));
            invalidate     = inval && (w == 1);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        invalidate     = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_data", read_data, NOP);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_req_addr", mem_req_address, 32'd0);
        rst = 1'b0;

        // First fill of line 0, hit appears the cycle after the last response.
        start_miss(32'h0);
        refill(32'h0, 0, 1'b0);
        #1;
        check("fill0_valid", 32'(read_valid), 32'd1);
        check("fill0_data", read_data, word_of(32'h0));

        for (int i = 1; i < WORDS; i++) begin
            @(negedge clk);
            read_address = 32'(4 * i);
            #1;
            check("hit_valid", 32'(read_valid), 32'd1);
            check("hit_data", read_data, word_of(32'(4 * i)));
            check("hit_no_req", 32'(mem_req_valid), 32'd0);
        end
        @(negedge clk);
        check("idle_no_req", 32'(mem_req_valid), 32'd0);

        // Ready held low for 5 cycles on a second line.
        start_miss(32'h40);
        refill(32'h40, 5, 1'b0);
        #1;
        check("stall_fill_valid", 32'(read_valid), 32'd1);
        check("stall_fill_data", read_data, word_of(32'h40));

        // Same-index conflict evicts line 0x0000.
        start_miss(32'h100);
        refill(32'h100, 0, 1'b0);
        #1;
        check("conflict_valid", 32'(read_valid), 32'd1);
        check("conflict_data", read_data, word_of(32'h100));

        // Refill 0x0 again with an invalidate during WAIT of the second word.
        start_miss(32'h0);
        refill(32'h0, 0, 1'b1);
        #1;
        check("inval_line_invalid", 32'(read_valid), 32'd0);
        check("inval_data_nop", read_data, NOP);
        @(negedge clk);
        check("inval_rerequest", 32'(mem_req_valid), 32'd1);
        check("inval_rereq_addr", mem_req_address, 32'h0);

        // Reset while waiting for a response; stray responses must be dropped.
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        check("rst_mid_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mid_req_addr", mem_req_address, 32'd0);
        check("rst_mid_read_valid", 32'(read_valid), 32'd0);
        rst          = 1'b0;
        read_address = 32'h40;
        #1;
        check("rst_cleared_0x40", 32'(read_valid), 32'd0);
        refill(32'h40, 0, 1'b0);
        #1;
        check("post_rst_valid", 32'(read_valid), 32'd1);
        check("post_rst_data", read_data, word_of(32'h40));
        @(negedge clk);
        read_address = 32'h4C;
        #1;
        check("post_rst_word3", read_data, word_of(32'h4C));

        // Invalidate in IDLE: hit this cycle, gone the next.
        @(negedge clk);
        invalidate = 1'b1;
        #1;
        check("idle_inval_same", 32'(read_valid), 32'd1);
        @(negedge clk);
        invalidate = 1'b0;
        #1;
        check("idle_inval_next", 32'(read_valid), 32'd0);
        check("idle_inval_nop", read_data, NOP);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
